// File: rtl/tsp_seg_display.sv
// tsp_seg_display
//   Multi-channel result display for the TSP wrapper. Latches up to NUM_CH
//   result words from the solver core. Shows the selected channel on
//   NUM_DIGITS active-low seven-segment digits, in hex or in decimal.
//   Decimal conversion uses a sequential double-dabble converter.
//
// Ports
//   clk      system clock
//   rst      synchronous reset, active high
//   ch_data  result words, channel k at [k*DATA_W +: DATA_W]
//   ch_valid one-cycle strobe per channel. There is no ready/backpressure:
//            a strobe sampled high at an edge always loads that channel.
//   sel      channel to display (out-of-range selects channel 0)
//   mode     0 = hex, 1 = decimal
//   hex      digit d at [d*7 +: 7], active low, bit0 = a .. bit6 = g,
//            digit 0 is rightmost
//   fresh    per-channel flag for a result that has not been displayed yet
//   busy     conversion in progress
module tsp_seg_display #(
   parameter int DATA_W     = 20,
   parameter int NUM_DIGITS = 6,
   parameter int NUM_CH     = 4,
   parameter int SEL_W      = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_W-1:0]     ch_data,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [SEL_W-1:0]             sel,
   input  logic                         mode,
   output logic [NUM_DIGITS*7-1:0]      hex,
   output logic [NUM_CH-1:0]            fresh,
   output logic                         busy
);

   localparam int BCD_W = 4 * (NUM_DIGITS + 1);
   localparam int EXT_W = DATA_W + 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_UPDATE} state_t;

   state_t             state;
   logic [DATA_W-1:0]  ch_reg [NUM_CH];
   logic [SEL_W-1:0]   sel_q;
   logic               mode_q;
   logic               pending;
   logic [DATA_W-1:0]  snap;       // snapshot; also the double-dabble shift source
   logic               snap_mode;
   logic [SEL_W-1:0]   snap_sel;
   logic [BCD_W-1:0]   bcd;
   logic               dd_ovf;     // a bit was shifted out of the top BCD nibble
   logic [CNT_W-1:0]   count;

   logic [SEL_W-1:0]   sel_eff;
   logic               pending_set;
   logic [BCD_W-1:0]   bcd_adj;
   logic [NUM_CH-1:0]  fresh_clr;
   logic [EXT_W-1:0]   ext;
   logic [4*NUM_DIGITS-1:0] digs;
   logic               ovf;
   logic               seen;
   logic [3:0]         nib;
   logic [NUM_DIGITS*7-1:0] hex_next;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      sel_eff = (32'(sel) < NUM_CH) ? sel : '0;
      pending_set = ch_valid[sel_eff] | (sel != sel_q) | (mode != mode_q);
   end

   // Double-dabble correction step: every nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < NUM_DIGITS + 1; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      fresh_clr = '0;
      if (state == S_UPDATE) fresh_clr[snap_sel] = 1'b1;
   end

   // Digit encoding, with overflow dashes and leading-zero blanking.
   always_comb begin
      ext = '0;
      ext[DATA_W-1:0] = snap;
      if (snap_mode) begin
         digs = bcd[4*NUM_DIGITS-1:0];
         ovf  = (|bcd[BCD_W-1 -: 4]) | dd_ovf;
      end else begin
         digs = ext[4*NUM_DIGITS-1:0];
         ovf  = |ext[EXT_W-1:4*NUM_DIGITS];
      end
      seen     = 1'b0;
      nib      = '0;
      hex_next = '1;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         nib = digs[d*4 +: 4];
         if (nib != 4'd0) seen = 1'b1;
         if (ovf)                  hex_next[d*7 +: 7] = SEG_DASH;
         else if (seen || d == 0)  hex_next[d*7 +: 7] = seg7(nib);
         else                      hex_next[d*7 +: 7] = SEG_BLANK;
      end
   end

   // Previous sel/mode for change detection; tracked through reset so that
   // leaving reset does not look like a change.
   always_ff @(posedge clk) begin
      sel_q  <= sel;
      mode_q <= mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) ch_reg[k] <= '0;
         fresh     <= '0;
         busy      <= 1'b0;
         state     <= S_IDLE;
         pending   <= 1'b1;
         hex       <= '1;
         snap      <= '0;
         snap_mode <= 1'b0;
         snap_sel  <= '0;
         bcd       <= '0;
         dd_ovf    <= 1'b0;
         count     <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_valid[k]) ch_reg[k] <= ch_data[k*DATA_W +: DATA_W];
         end
         // A new strobe wins over the clear from a coincident update.
         fresh <= (fresh & ~fresh_clr) | ch_valid;

         if (state == S_IDLE && pending) pending <= pending_set;
         else                            pending <= pending | pending_set;

         case (state)
            S_IDLE: begin
               if (pending) begin
                  state <= S_LOAD;
                  busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               snap      <= ch_reg[sel_eff];
               snap_mode <= mode;
               snap_sel  <= sel_eff;
               bcd       <= '0;
               dd_ovf    <= 1'b0;
               count     <= '0;
               state     <= mode ? S_SHIFT : S_UPDATE;
            end
            S_SHIFT: begin
               bcd    <= {bcd_adj[BCD_W-2:0], snap[DATA_W-1]};
               dd_ovf <= dd_ovf | bcd_adj[BCD_W-1];
               snap   <= snap << 1;
               count  <= count + CNT_W'(1);
               if (count == CNT_W'(DATA_W - 1)) state <= S_UPDATE;
            end
            default: begin
               hex   <= hex_next;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tsp_seg_display.sv
module tb_tsp_seg_display;

   localparam int DATA_W     = 20;
   localparam int NUM_DIGITS = 6;
   localparam int NUM_CH     = 4;
   localparam int SEL_W      = 2;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DS = 7'b0111111;
   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GF = 7'b0001110;

   logic                          clk;
   logic                          rst;
   logic [NUM_CH*DATA_W-1:0]      ch_data;
   logic [NUM_CH-1:0]             ch_valid;
   logic [SEL_W-1:0]              sel;
   logic                          mode;
   logic [NUM_DIGITS*7-1:0]       hex;
   logic [NUM_CH-1:0]             fresh;
   logic                          busy;

   int checks = 0;
   int errors = 0;

   logic [41:0] all_blank;
   logic [41:0] cur_disp;

   tsp_seg_display #(
      .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .NUM_CH(NUM_CH), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
      .sel(sel), .mode(mode), .hex(hex), .fresh(fresh), .busy(busy)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [41:0] disp6(input logic [6:0] g5, g4, g3, g2, g1, g0);
      return {g5, g4, g3, g2, g1, g0};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive helpers: inputs change 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ch(input int k, input logic [DATA_W-1:0] v);
      ch_data[k*DATA_W +: DATA_W] = v;
      ch_valid = '0;
      ch_valid[k] = 1'b1;
      tick();
      ch_valid = '0;
   endtask

   // From the trigger edge, expect the display to hold `prev` for lat-1 edges,
   // busy high throughout, then show `exp` at edge lat with busy low.
   task automatic run_and_expect(input string tag, input int lat,
                                 input logic [41:0] prev, input logic [41:0] exp);
      int bc = 0;
      for (int i = 1; i < lat; i++) begin
         tick();
         if (busy === 1'b1) bc++;
         check({tag, "_hold"}, 64'(hex), 64'(prev));
      end
      tick();
      check({tag, "_disp"}, 64'(hex), 64'(exp));
      check({tag, "_busy_done"}, 64'(busy), 64'(0));
      check({tag, "_busy_len"}, 64'(bc), 64'(lat - 1));
      cur_disp = exp;
   endtask

   initial begin
      all_blank = disp6(BL, BL, BL, BL, BL, BL);
      cur_disp  = all_blank;
      rst = 1'b1; ch_data = '0; ch_valid = '0; sel = '0; mode = 1'b0;

      // Reset held 5 cycles
      repeat (5) begin
         tick();
         check("rst_hex", 64'(hex), 64'(all_blank));
      end
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_fresh", 64'(fresh), 64'(0));
      rst = 1'b0;
      run_and_expect("post_rst", 3, all_blank, disp6(BL, BL, BL, BL, BL, G0));
      tick();
      check("post_rst_single", 64'(busy), 64'(0));

      // Decimal 123456
      mode = 1'b1;
      drive_ch(0, 20'd123456);
      check("dec_fresh_set", 64'(fresh), 64'(4'b0001));
      run_and_expect("dec", 23, cur_disp, disp6(G1, G2, G3, G4, G5, G6));
      check("dec_fresh_clr", 64'(fresh), 64'(4'b0000));

      // Same data in hex: 0x1E240
      mode = 1'b0;
      tick();
      run_and_expect("hex", 3, cur_disp, disp6(BL, G1, GE, G2, G4, G0));

      // Overflow in decimal, then FFFFF in hex
      mode = 1'b1;
      drive_ch(0, 20'hFFFFF);
      run_and_expect("ovf_dec", 23, cur_disp, disp6(DS, DS, DS, DS, DS, DS));
      mode = 1'b0;
      tick();
      run_and_expect("ovf_hex", 3, cur_disp, disp6(BL, GF, GF, GF, GF, GF));

      // Back-to-back triggers; second strobe lands on the LOAD edge
      drive_ch(0, 20'd5);
      tick();
      check("b2b_busy1", 64'(busy), 64'(1));
      drive_ch(0, 20'd7);
      tick();
      check("b2b_first", 64'(hex), 64'(disp6(BL, BL, BL, BL, BL, G5)));
      check("b2b_idle", 64'(busy), 64'(0));
      tick();
      check("b2b_busy2", 64'(busy), 64'(1));
      tick();
      check("b2b_hold", 64'(hex), 64'(disp6(BL, BL, BL, BL, BL, G5)));
      // Strobe coinciding with the update edge: fresh must stay set
      drive_ch(0, 20'd7);
      check("b2b_second", 64'(hex), 64'(disp6(BL, BL, BL, BL, BL, G7)));
      check("set_wins", 64'(fresh), 64'(4'b0001));
      run_and_expect("b2b_third", 3, disp6(BL, BL, BL, BL, BL, G7),
                     disp6(BL, BL, BL, BL, BL, G7));
      check("b2b_fresh_clr", 64'(fresh), 64'(0));

      // Unselected channel: fresh only
      drive_ch(2, 20'd42);
      check("ch2_fresh", 64'(fresh), 64'(4'b0100));
      check("ch2_busy", 64'(busy), 64'(0));
      tick();
      tick();
      check("ch2_no_conv", 64'(busy), 64'(0));
      check("ch2_disp_kept", 64'(hex), 64'(cur_disp));
      sel = 2'd2;
      tick();
      run_and_expect("sel2", 3, cur_disp, disp6(BL, BL, BL, BL, G2, GA));
      check("sel2_fresh", 64'(fresh), 64'(0));

      // Reset during SHIFT aborts
      mode = 1'b1;
      tick();
      drive_ch(1, 20'd9);
      repeat (8) tick();
      check("abort_busy", 64'(busy), 64'(1));
      check("abort_fresh_pre", 64'(fresh), 64'(4'b0010));
      rst = 1'b1;
      tick();
      check("abort_hex", 64'(hex), 64'(all_blank));
      check("abort_busy0", 64'(busy), 64'(0));
      check("abort_fresh", 64'(fresh), 64'(0));
      rst = 1'b0;
      run_and_expect("abort_reconv", 23, all_blank, disp6(BL, BL, BL, BL, BL, G0));
      repeat (3) tick();
      check("final_idle", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
